// File: rtl/tcp_tx_builder.sv
// TCP segment builder: emits a 20-byte TCP header, then the payload bytes.
// Define TCP_TX_MSS_OPT_EN to append the 4-byte MSS option on SYN segments.
`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

module tcp_tx_builder #(
    parameter int          DATA_WIDTH = `INPUTWIDTH,
    parameter logic [15:0] MSS_VALUE  = 16'd1460
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  meta_valid,
    output logic                  meta_ready,
    input  logic [15:0]           meta_src_port,
    input  logic [15:0]           meta_dst_port,
    input  logic [31:0]           meta_seq_num,
    input  logic [31:0]           meta_ack_num,
    input  logic [7:0]            meta_flags,
    input  logic [15:0]           meta_window_size,
    input  logic [15:0]           meta_payload_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  err_short
);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [31:0] seq_q;
    logic [31:0] ack_q;
    logic [7:0]  flags_q;
    logic [15:0] win_q;
    logic [15:0] len_q;
    logic [15:0] cnt;
    logic [4:0]  idx;
    logic [4:0]  hdr_last;
    logic [3:0]  doff;
    logic [7:0]  hdr_byte;
    logic        pay_end;
    logic        err_q;

`ifdef TCP_TX_MSS_OPT_EN
    always_comb begin
        hdr_last = flags_q[1] ? 5'd23 : 5'd19;
        doff     = flags_q[1] ? 4'd6 : 4'd5;
    end
`else
    assign hdr_last = 5'd19;
    assign doff     = 4'd5;
`endif

    assign pay_end   = (cnt + 16'd1) == len_q;
    assign err_short = err_q;

    always_comb begin
        hdr_byte = 8'h00;
        unique case (idx)
            5'd0:    hdr_byte = src_q[15:8];
            5'd1:    hdr_byte = src_q[7:0];
            5'd2:    hdr_byte = dst_q[15:8];
            5'd3:    hdr_byte = dst_q[7:0];
            5'd4:    hdr_byte = seq_q[31:24];
            5'd5:    hdr_byte = seq_q[23:16];
            5'd6:    hdr_byte = seq_q[15:8];
            5'd7:    hdr_byte = seq_q[7:0];
            5'd8:    hdr_byte = ack_q[31:24];
            5'd9:    hdr_byte = ack_q[23:16];
            5'd10:   hdr_byte = ack_q[15:8];
            5'd11:   hdr_byte = ack_q[7:0];
            5'd12:   hdr_byte = {doff, 4'h0};
            5'd13:   hdr_byte = flags_q;
            5'd14:   hdr_byte = win_q[15:8];
            5'd15:   hdr_byte = win_q[7:0];
`ifdef TCP_TX_MSS_OPT_EN
            5'd20:   hdr_byte = 8'h02;
            5'd21:   hdr_byte = 8'h04;
            5'd22:   hdr_byte = MSS_VALUE[15:8];
            5'd23:   hdr_byte = MSS_VALUE[7:0];
`endif
            // checksum and urgent pointer stay zero; checksum is filled downstream
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        meta_ready    = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = 1'b0;
        unique case (state)
            IDLE: begin
                meta_ready = !rst;
                if (meta_valid) state_nxt = HEADER;
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = DATA_WIDTH'(hdr_byte);
                m_axis_tlast  = (idx == hdr_last) && (len_q == 16'd0);
                if (m_axis_tready && idx == hdr_last)
                    state_nxt = (len_q == 16'd0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                // an early source tlast closes the segment short
                m_axis_tlast  = pay_end || s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready && m_axis_tlast)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            seq_q   <= '0;
            ack_q   <= '0;
            flags_q <= '0;
            win_q   <= '0;
            len_q   <= '0;
            cnt     <= '0;
            idx     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    idx <= '0;
                    cnt <= '0;
                    if (meta_valid) begin
                        src_q   <= meta_src_port;
                        dst_q   <= meta_dst_port;
                        seq_q   <= meta_seq_num;
                        ack_q   <= meta_ack_num;
                        flags_q <= meta_flags;
                        win_q   <= meta_window_size;
                        len_q   <= meta_payload_len;
                    end
                end
                HEADER: begin
                    if (m_axis_tready) idx <= idx + 5'd1;
                end
                PAYLOAD: begin
                    if (s_axis_tvalid && m_axis_tready) begin
                        cnt   <= cnt + 16'd1;
                        err_q <= s_axis_tlast && !pay_end;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx_builder.sv
// Directed bench for tcp_tx_builder: header layout, payload pass-through,
// backpressure, short payload, reset abandon and (optionally) the MSS option.
module tb_tcp_tx_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        meta_valid;
    logic        meta_ready;
    logic [15:0] meta_src_port;
    logic [15:0] meta_dst_port;
    logic [31:0] meta_seq_num;
    logic [31:0] meta_ack_num;
    logic [7:0]  meta_flags;
    logic [15:0] meta_window_size;
    logic [15:0] meta_payload_len;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        err_short;

    tcp_tx_builder #(.DATA_WIDTH(8), .MSS_VALUE(16'd1460)) dut (
        .clk(clk),
        .rst(rst),
        .meta_valid(meta_valid),
        .meta_ready(meta_ready),
        .meta_src_port(meta_src_port),
        .meta_dst_port(meta_dst_port),
        .meta_seq_num(meta_seq_num),
        .meta_ack_num(meta_ack_num),
        .meta_flags(meta_flags),
        .meta_window_size(meta_window_size),
        .meta_payload_len(meta_payload_len),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .err_short(err_short)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [7:0] src_d[$];
    int         src_last;
    int         src_pos;
    logic [7:0] out_q[$];
    logic       last_q[$];
    logic [7:0] exp_q[$];

    int   cyc = 0;
    int   meta_cyc, first_cyc, tlast_cyc, err_cyc;
    int   vcnt, err_cnt, mr_err, stab_err;
    bit   done, in_seg, srdy_seen, tgl, s_fire, last_mr;
    bit   prev_v, prev_r, prev_l;
    logic [7:0] prev_d;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void drive_src();
        s_axis_tvalid = src_pos < src_d.size();
        s_axis_tdata  = s_axis_tvalid ? src_d[src_pos] : 8'h00;
        s_axis_tlast  = s_axis_tvalid && (src_pos == src_last);
    endfunction

    function automatic void load_src(input int last_at);
        src_last = last_at;
        src_pos  = 0;
        drive_src();
    endfunction

    task automatic step();
        bit mfire;
        @(negedge clk);
        cyc++;
        mfire = 1'b0;
        if (in_seg && meta_ready) mr_err++;
        if (s_axis_tready) srdy_seen = 1'b1;
        if (err_short) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (prev_v && !prev_r) begin
            if (!m_axis_tvalid || m_axis_tdata != prev_d ||
                m_axis_tlast != prev_l)
                stab_err++;
        end
        prev_v = m_axis_tvalid;
        prev_r = m_axis_tready;
        prev_d = m_axis_tdata;
        prev_l = m_axis_tlast;
        if (m_axis_tvalid && in_seg) begin
            vcnt++;
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back(m_axis_tdata);
            last_q.push_back(m_axis_tlast);
            if (m_axis_tlast) begin
                done      = 1'b1;
                tlast_cyc = cyc;
                in_seg    = 1'b0;
            end
        end
        if (meta_valid && meta_ready) begin
            in_seg   = 1'b1;
            meta_cyc = cyc;
            mfire    = 1'b1;
        end
        s_fire  = s_axis_tvalid && s_axis_tready;
        last_mr = meta_ready;
        @(posedge clk);
        #1;
        if (s_fire) src_pos++;
        drive_src();
        if (mfire) meta_valid = 1'b0;
        m_axis_tready = tgl ? !m_axis_tready : 1'b1;
    endtask

    task automatic start_seg(input logic [7:0] fl, input logic [15:0] ln,
                             input bit toggle);
        meta_src_port    = 16'h1234;
        meta_dst_port    = 16'h0050;
        meta_seq_num     = 32'h01020304;
        meta_ack_num     = 32'hA0B0C0D0;
        meta_flags       = fl;
        meta_window_size = 16'h2000;
        meta_payload_len = ln;
        meta_valid       = 1'b1;
        tgl              = toggle;
        m_axis_tready    = 1'b1;
        out_q.delete();
        last_q.delete();
        done      = 1'b0;
        in_seg    = 1'b0;
        first_cyc = -1;
        err_cyc   = -1;
        tlast_cyc = -1;
        vcnt      = 0;
        err_cnt   = 0;
        mr_err    = 0;
        stab_err  = 0;
        srdy_seen = 1'b0;
        prev_v    = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        while (!done && n < 400) begin
            step();
            n++;
        end
        check({nm, "_done"}, 32'(done), 32'd1);
        tgl = 1'b0;
        repeat (3) step();
    endtask

    task automatic cmp_out(input string nm);
        check({nm, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_q.size()) begin
                check($sformatf("%s_b%0d", nm, i), 32'(out_q[i]),
                      32'(exp_q[i]));
                check($sformatf("%s_l%0d", nm, i), 32'(last_q[i]),
                      32'(i == exp_q.size() - 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        meta_valid = 1'b0;
        meta_src_port = '0;
        meta_dst_port = '0;
        meta_seq_num = '0;
        meta_ack_num = '0;
        meta_flags = '0;
        meta_window_size = '0;
        meta_payload_len = '0;
        m_axis_tready = 1'b1;
        tgl = 1'b0;
        src_d = {};
        load_src(-1);

        @(negedge clk);
        check("rst_mready", 32'(meta_ready), 0);
        check("rst_mvalid", 32'(m_axis_tvalid), 0);
        check("rst_sready", 32'(s_axis_tready), 0);
        check("rst_err", 32'(err_short), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_mready", 32'(meta_ready), 1);
        @(posedge clk);
        #1;

        // s1: basic segment, 3 payload bytes, tready held high
        src_d = '{8'hAA, 8'hBB, 8'hCC};
        load_src(2);
        start_seg(8'h18, 16'd3, 1'b0);
        wait_end("s1");
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h18, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        cmp_out("s1");
        check("s1_latency", first_cyc - meta_cyc, 1);
        check("s1_span", tlast_cyc - first_cyc + 1, 23);
        check("s1_vcnt", vcnt, 23);
        check("s1_err", err_cnt, 0);

        // s2: header-only segment
        src_d = {};
        load_src(-1);
        start_seg(8'h10, 16'd0, 1'b0);
        wait_end("s2");
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h10, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00};
        cmp_out("s2");
        check("s2_sready", 32'(srdy_seen), 0);

        // s3: s1 with tready toggling every cycle
        src_d = '{8'hAA, 8'hBB, 8'hCC};
        load_src(2);
        start_seg(8'h18, 16'd3, 1'b1);
        wait_end("s3");
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h18, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        cmp_out("s3");
        check("s3_stable", stab_err, 0);
        check("s3_mready", mr_err, 0);

        // s4: payload ends after 2 of 5 bytes
        src_d = '{8'h11, 8'h22};
        load_src(1);
        start_seg(8'h18, 16'd5, 1'b0);
        wait_end("s4");
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h18, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        cmp_out("s4");
        check("s4_errcnt", err_cnt, 1);
        check("s4_errcyc", err_cyc - tlast_cyc, 1);
        check("s4_idle", 32'(last_mr), 1);

        // s5: reset while header byte 7 is on the bus
        src_d = '{8'hAA, 8'hBB, 8'hCC};
        load_src(2);
        start_seg(8'h18, 16'd3, 1'b0);
        for (int n = 0; n < 100 && out_q.size() < 7; n++) step();
        check("s5_pre", out_q.size(), 7);
        rst = 1'b1;
        @(negedge clk);
        check("s5_mready", 32'(meta_ready), 0);
        check("s5_mvalid", 32'(m_axis_tvalid), 0);
        check("s5_mlast", 32'(m_axis_tlast), 0);
        check("s5_mdata", 32'(m_axis_tdata), 0);
        check("s5_sready", 32'(s_axis_tready), 0);
        check("s5_err", 32'(err_short), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("s5_rel", 32'(meta_ready), 1);
        @(posedge clk);
        #1;
        load_src(2);
        start_seg(8'h18, 16'd3, 1'b0);
        wait_end("s5b");
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h18, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        cmp_out("s5b");

        // s7: extra source bytes wait for the next descriptor
        src_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load_src(-1);
        start_seg(8'h18, 16'd2, 1'b0);
        wait_end("s7a");
        check("s7a_left", src_pos, 2);
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h18, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        cmp_out("s7a");
        start_seg(8'h18, 16'd2, 1'b0);
        wait_end("s7b");
        check("s7b_left", src_pos, 4);
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h18, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'hCC, 8'hDD};
        cmp_out("s7b");

`ifdef TCP_TX_MSS_OPT_EN
        // s6: SYN carries the MSS option, non-SYN does not
        src_d = {};
        load_src(-1);
        start_seg(8'h02, 16'd0, 1'b0);
        wait_end("s6a");
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h60, 8'h02, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h05, 8'hB4};
        cmp_out("s6a");
        start_seg(8'h10, 16'd0, 1'b0);
        wait_end("s6b");
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h50, 8'h10, 8'h20, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00};
        cmp_out("s6b");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
